// File: rtl/hazard_control_unit.sv
// ============================================================================
// hazard_control_unit
// ----------------------------------------------------------------------------
// Pipeline hazard arbiter that sits beside the ID stage of the in-order
// RISC-V pipeline. It detects load-use hazards, inserts a configurable number
// of bubbles per hazard, and arbitrates those bubbles against data-memory
// busy freezes and taken-branch flushes. It also keeps a saturating count of
// cycles in which the front end (stall) or back end (freeze) was held.
//
// Priority, highest first: freeze (mem_busy_i), flush (branch_taken_i),
// load-use bubble.
//
// Parameters
//   REG_ADDR_W       register index width
//   LOAD_USE_CYCLES  bubbles inserted per load-use hazard (1..15)
//   CNT_W            width of the stall-cycle counter
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-high reset
//   ex_mem_read_i    EX instruction is a load
//   ex_rd_i          EX destination register
//   id_rs1_i/rs2_i   ID source registers
//   id_use_rs1_i/2_i ID instruction actually reads rs1 / rs2
//   mem_busy_i       data memory not ready, whole pipeline holds
//   branch_taken_i   taken branch/jump resolved in EX
//   cnt_clr_i        synchronous clear of the stall counter
//   noop_o           zero the control bits entering ID/EX
//   stall_o          hold IF/ID
//   pc_write_o       PC update enable
//   flush_o          flush IF/ID and ID/EX
//   freeze_o         hold ID/EX, EX/MEM, MEM/WB
//   stall_cycles_o   saturating count of cycles with stall_o or freeze_o
// ============================================================================
module hazard_control_unit #(
  parameter int REG_ADDR_W      = 5,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_use_rs1_i,
  input  logic                  id_use_rs2_i,
  input  logic                  mem_busy_i,
  input  logic                  branch_taken_i,
  input  logic                  cnt_clr_i,
  output logic                  noop_o,
  output logic                  stall_o,
  output logic                  pc_write_o,
  output logic                  flush_o,
  output logic                  freeze_o,
  output logic [CNT_W-1:0]      stall_cycles_o
);

  // The remaining-bubble counter is 4 bits wide, which bounds the distance.
  if (LOAD_USE_CYCLES < 1 || LOAD_USE_CYCLES > 15) begin : g_bad_param
    $error("hazard_control_unit: LOAD_USE_CYCLES must be in 1..15");
  end

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_t;

  // Bubbles still owed after the one issued in the detection cycle.
  localparam logic [3:0] REM_INIT   = 4'(LOAD_USE_CYCLES - 1);
  localparam bit         MULTI_BUBB = (LOAD_USE_CYCLES > 1);

  state_t     state, state_nxt;
  logic [3:0] rem,   rem_nxt;
  logic       hazard;

  // --------------------------------------------------------------------------
  // Load-use detection. x0 is never a real producer, and a source field that
  // the instruction does not read may hold arbitrary encoding bits.
  // --------------------------------------------------------------------------
  always_comb begin
    hazard = ex_mem_read_i && (ex_rd_i != '0) &&
             (((ex_rd_i == id_rs1_i) && id_use_rs1_i) ||
              ((ex_rd_i == id_rs2_i) && id_use_rs2_i));
  end

  // --------------------------------------------------------------------------
  // Output decode and next-state logic.
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    noop_o     = 1'b0;
    stall_o    = 1'b0;
    pc_write_o = 1'b0;
    flush_o    = 1'b0;
    freeze_o   = 1'b0;
    state_nxt  = state;
    rem_nxt    = rem;

    if (rst_i) begin
      // Reset is asynchronous; keep every control output low, PC included,
      // for as long as it is asserted.
      state_nxt = RUN;
      rem_nxt   = '0;
    end else if (mem_busy_i) begin
      // Whole pipeline holds. State is untouched so a pending branch or
      // hazard is re-evaluated once memory is ready again.
      freeze_o = 1'b1;
      stall_o  = 1'b1;
    end else if (branch_taken_i) begin
      // The ID instruction is wrong-path, so any bubble train it caused is
      // abandoned.
      flush_o    = 1'b1;
      pc_write_o = 1'b1;
      state_nxt  = RUN;
      rem_nxt    = '0;
    end else if (state == LU_STALL) begin
      // EX now holds a bubble, so the hazard term no longer fires; keep
      // bubbling until the owed count runs out.
      noop_o  = 1'b1;
      stall_o = 1'b1;
      rem_nxt = rem - 4'd1;
      if (rem == 4'd1) begin
        state_nxt = RUN;
      end
    end else if (hazard) begin
      // First bubble goes out in the detection cycle itself.
      noop_o  = 1'b1;
      stall_o = 1'b1;
      if (MULTI_BUBB) begin
        state_nxt = LU_STALL;
        rem_nxt   = REM_INIT;
      end
    end else begin
      pc_write_o = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // State registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (rst_i) begin
      state <= RUN;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Saturating stall-cycle counter; clear wins over increment.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cycles_o <= '0;
    end else if (cnt_clr_i) begin
      stall_cycles_o <= '0;
    end else if ((stall_o || freeze_o) && (stall_cycles_o != '1)) begin
      stall_cycles_o <= stall_cycles_o + 1'b1;
    end
  end

endmodule
